simd_issue: RTL and testbench

- Upstream issue/sequencer stage for the packed-SIMD MAC unit. Accepts one decoded SIMD operation per request from the core's execute stage and drives the MAC unit's ctrl/a/b/valid_in interface.
- Holds operands stable for the whole MAC computation and captures the MAC result into a one-entry response buffer.
- Returns the result to writeback with a valid/ready handshake, tagged with the destination register and the measured MAC latency.

---
 rtl/simd_issue_if.sv | 42 ++++
 rtl/simd_issue.sv | 140 ++++++++++++++
 tb/tb_simd_issue.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/simd_issue_if.sv
// Request, MAC and writeback signal bundle for the SIMD issue/sequencer stage.
// slave = the issue block, master = its environment (core, MAC unit, writeback).
interface simd_issue_if #(
  parameter int TAG_W = 5,
  parameter int LAT_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [TAG_W-1:0] req_rd;

  logic [1:0]       mac_ctrl;
  logic [31:0]      mac_a;
  logic [31:0]      mac_b;
  logic             mac_valid_in;
  logic             mac_valid_out;
  logic [31:0]      mac_result;

  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_rd;
  logic [LAT_W-1:0] resp_latency;
  logic             resp_err;
  logic             busy;

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_rd,
    input  mac_valid_out, mac_result, resp_ready,
    output req_ready, mac_ctrl, mac_a, mac_b, mac_valid_in,
    output resp_valid, resp_data, resp_rd, resp_latency, resp_err, busy
  );

  modport master (
    output req_valid, req_op, req_a, req_b, req_rd,
    output mac_valid_out, mac_result, resp_ready,
    input  req_ready, mac_ctrl, mac_a, mac_b, mac_valid_in,
    input  resp_valid, resp_data, resp_rd, resp_latency, resp_err, busy
  );
endinterface

// File: rtl/simd_issue.sv
// Issue/sequencer stage in front of the packed-SIMD MAC: holds operands, pulses the start,
// buffers one tagged response. Define SIMD_ISSUE_TIMEOUT_EN to add the WAIT-cycle timeout.
module simd_issue #(
  parameter int TAG_W   = 5,
  parameter int LAT_W   = 4,
  parameter int TIMEOUT = 12
) (
  input logic      clk,
  input logic      rst_n,
  simd_issue_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

`ifdef SIMD_ISSUE_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  localparam logic [LAT_W-1:0] TMO_CNT = LAT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic [1:0]       op_p0;
  logic [31:0]      a_p0, b_p0;
  logic [TAG_W-1:0] rd_p0;
  logic [LAT_W-1:0] lat_p0;
  logic             vld_p1;
  logic [31:0]      data_p1;
  logic [TAG_W-1:0] rd_p1;
  logic [LAT_W-1:0] lat_p1;
  logic             accept, done_ok, done_tmo, tmo_hit;
  logic [LAT_W-1:0] lat_next;

  function automatic logic [LAT_W-1:0] sat_inc(input logic [LAT_W-1:0] v);
    return (&v) ? v : v + LAT_W'(1);
  endfunction

  assign lat_next      = sat_inc(lat_p0);
  assign tmo_hit       = TMO_EN && (lat_next == TMO_CNT);
  assign bus.req_ready = (state_q == IDLE) && (!vld_p1 || bus.resp_ready);
  assign accept        = bus.req_valid && bus.req_ready;

  always_comb begin
    state_d  = state_q;
    done_ok  = 1'b0;
    done_tmo = 1'b0;
    case (state_q)
      IDLE:  if (accept) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (bus.mac_valid_out) begin
          done_ok = 1'b1;
          state_d = DRAIN;
        end else if (tmo_hit) begin
          done_tmo = 1'b1;
          state_d  = DRAIN;
        end
      end
      // DRAIN gives the MAC one cycle to drop valid_out before the next start pulse
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---- p0: operand hold, driven to the MAC for the whole computation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_p0 <= '0;
      a_p0  <= '0;
      b_p0  <= '0;
      rd_p0 <= '0;
    end else if (accept) begin
      op_p0 <= bus.req_op;
      a_p0  <= bus.req_a;
      b_p0  <= bus.req_b;
      rd_p0 <= bus.req_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                 lat_p0 <= '0;
    else if (accept)            lat_p0 <= '0;
    else if (state_q == WAIT)   lat_p0 <= lat_next;
  end

  // ---- p1: one-entry response buffer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      rd_p1   <= '0;
      lat_p1  <= '0;
    end else if (done_ok) begin
      vld_p1  <= 1'b1;
      data_p1 <= bus.mac_result;
      rd_p1   <= rd_p0;
      lat_p1  <= lat_next;
    end else if (done_tmo) begin
      vld_p1  <= 1'b1;
      data_p1 <= '0;
      rd_p1   <= rd_p0;
      lat_p1  <= TMO_CNT;
    end else if (vld_p1 && bus.resp_ready) begin
      vld_p1  <= 1'b0;
    end
  end

`ifdef SIMD_ISSUE_TIMEOUT_EN
  logic err_p1;
  always_ff @(posedge clk) begin
    if (!rst_n)        err_p1 <= 1'b0;
    else if (done_ok)  err_p1 <= 1'b0;
    else if (done_tmo) err_p1 <= 1'b1;
  end
  assign bus.resp_err = err_p1;
`else
  assign bus.resp_err = 1'b0;
`endif

  assign bus.mac_ctrl     = op_p0;
  assign bus.mac_a        = a_p0;
  assign bus.mac_b        = b_p0;
  assign bus.mac_valid_in = (state_q == ISSUE);
  assign bus.resp_valid   = vld_p1;
  assign bus.resp_data    = data_p1;
  assign bus.resp_rd      = rd_p1;
  assign bus.resp_latency = lat_p1;
  assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_simd_issue.sv
// Bench for simd_issue: stub MAC with per-op latency, expected-response queue, directed + random steps.
module tb_simd_issue;
  localparam int TAG_W   = 5;
  localparam int LAT_W   = 4;
  localparam int TIMEOUT = 12;

  typedef struct {
    int          first;
    logic [31:0] data;
    logic [4:0]  rd;
    logic [3:0]  lat;
    logic        err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   ncmp = 0;
  int   nfail = 0;
  exp_t q[$];
  int   last_acc = -10;
  logic [1:0]  exp_op = '0;
  logic [31:0] exp_a = '0, exp_b = '0;
  int   rr_mode = 0;
  bit   prev_rv = 1'b0;

  int   stub_cnt;
  bit   stub_en = 1'b1;
  int   lat_ovr = 0;
  bit   spur = 1'b0;

  simd_issue_if #(.TAG_W(TAG_W), .LAT_W(LAT_W)) bus ();

  simd_issue #(.TAG_W(TAG_W), .LAT_W(LAT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // MAC reference behaviour: cycles per op, and result values for the known vectors
  function automatic int wait_n(input logic [1:0] op);
    case (op)
      2'b00:   return 2;
      2'b01:   return 5;
      2'b10:   return 6;
      default: return 5;
    endcase
  endfunction

  function automatic logic [31:0] mac_fn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == 2'b00 && a == 32'h7F01FF80 && b == 32'h01010180) return 32'h8002FE00;
    if (op == 2'b01 && a == 32'h0000FE03 && b == 32'h00000705) return 32'hFFF2000F;
    if (op == 2'b10 && a == 32'h01020304 && b == 32'h01010101) return 32'h0000000A;
    if (op == 2'b11 && a == 32'h02FF0000 && b == 32'h03020000) return 32'h0006FFFE;
    return (a ^ {b[15:0], b[31:16]}) + {30'd0, op};
  endfunction

  function automatic logic [3:0] sat_lat(input int n);
    return (n > 15) ? 4'd15 : 4'(n);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n)                             stub_cnt <= 0;
    else if (bus.mac_valid_in && stub_en)   stub_cnt <= (lat_ovr != 0) ? lat_ovr : wait_n(bus.mac_ctrl);
    else if (stub_cnt != 0)                 stub_cnt <= stub_cnt - 1;
  end
  assign bus.mac_valid_out = (stub_cnt == 1) || spur;
  assign bus.mac_result    = (stub_cnt == 1) ? mac_fn(bus.mac_ctrl, bus.mac_a, bus.mac_b) : 32'hDEADBEEF;

  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0:       bus.resp_ready = 1'b1;
      1:       bus.resp_ready = 1'($urandom_range(0, 1));
      default: bus.resp_ready = 1'b0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Writeback-side monitor: operand hold, start pulse timing, response contents and order
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mac_valid_in) check("vin_cycle", 64'(cyc), 64'(last_acc + 1));
      if (bus.busy) begin
        check("mac_ctrl_hold", 64'(bus.mac_ctrl), 64'(exp_op));
        check("mac_a_hold", 64'(bus.mac_a), 64'(exp_a));
        check("mac_b_hold", 64'(bus.mac_b), 64'(exp_b));
      end
      if (q.size() == 0) begin
        check("resp_idle", 64'(bus.resp_valid), 64'd0);
      end else if (bus.resp_valid) begin
        if (!prev_rv) check("resp_first_cycle", 64'(cyc), 64'(q[0].first));
        check("resp_data", 64'(bus.resp_data), 64'(q[0].data));
        check("resp_rd", 64'(bus.resp_rd), 64'(q[0].rd));
        check("resp_latency", 64'(bus.resp_latency), 64'(q[0].lat));
        check("resp_err", 64'(bus.resp_err), 64'(q[0].err));
        if (bus.resp_ready) void'(q.pop_front());
      end
    end
    prev_rv = bus.resp_valid;
  end

  // mode: 0 no response expected, 1 normal MAC result, 2 timeout response
  task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int mode);
    bit accepted = 1'b0;
    int n;
    @(posedge clk); #1;
    bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_rd = rd;
    bus.req_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        accepted = 1'b1;
        last_acc = cyc;
        exp_op = op; exp_a = a; exp_b = b;
        n = (lat_ovr != 0) ? lat_ovr : wait_n(op);
        if (mode == 1) q.push_back('{cyc + n + 2, mac_fn(op, a, b), rd, sat_lat(n), 1'b0});
        if (mode == 2) q.push_back('{cyc + TIMEOUT + 2, 32'd0, rd, 4'(TIMEOUT), 1'b1});
        break;
      end
    end
    check("req_accept", 64'(accepted), 64'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_a = $urandom; bus.req_b = $urandom;
    bus.req_op = 2'($urandom_range(0, 3)); bus.req_rd = 5'($urandom_range(0, 31));
  endtask

  task automatic wait_quiet(input int budget);
    bit ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (q.size() == 0 && !bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain_done", 64'(ok), 64'd1);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_vin", 64'(bus.mac_valid_in), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=time_limit expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0; bus.req_rd = '0;
    bus.resp_ready = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", 64'(bus.req_ready), 64'd1);
    check("reset_mac_ctrl", 64'(bus.mac_ctrl), 64'd0);
    check("reset_mac_a", 64'(bus.mac_a), 64'd0);
    check("reset_mac_b", 64'(bus.mac_b), 64'd0);
    check("reset_mac_vin", 64'(bus.mac_valid_in), 64'd0);
    check("reset_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("reset_resp_data", 64'(bus.resp_data), 64'd0);
    check("reset_resp_rd", 64'(bus.resp_rd), 64'd0);
    check("reset_resp_lat", 64'(bus.resp_latency), 64'd0);
    check("reset_resp_err", 64'(bus.resp_err), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // directed vectors
    do_req(2'b00, 32'h7F01FF80, 32'h01010180, 5'd1, 1);
    wait_quiet(40);
    do_req(2'b01, 32'h0000FE03, 32'h00000705, 5'd2, 1);
    wait_quiet(40);
    do_req(2'b10, 32'h01020304, 32'h01010101, 5'd7, 1);
    do_req(2'b11, 32'h02FF0000, 32'h03020000, 5'd31, 1);
    wait_quiet(60);

    // back-pressure: buffered response must survive a waiting request
    rr_mode = 2;
    do_req(2'b00, 32'h7F01FF80, 32'h01010180, 5'd3, 1);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("bp_resp_seen", 64'(seen), 64'd1);
    @(posedge clk); #1;
    bus.req_op = 2'b01; bus.req_a = 32'h0000FE03; bus.req_b = 32'h00000705; bus.req_rd = 5'd4;
    bus.req_valid = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("bp_req_ready", 64'(bus.req_ready), 64'd0);
      check("bp_hold_data", 64'(bus.resp_data), 64'h8002FE00);
    end
    rr_mode = 0;
    do_req(2'b01, 32'h0000FE03, 32'h00000705, 5'd4, 1);
    wait_quiet(40);

    // reset in the middle of a PVMAC wait
    do_req(2'b10, 32'h01020304, 32'h01010101, 5'd9, 0);
    repeat (2) @(posedge clk);
    pulse_reset();
    do_req(2'b00, 32'h7F01FF80, 32'h01010180, 5'd10, 1);
    wait_quiet(40);

    // stray valid_out while idle
    @(posedge clk); #1;
    spur = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("spur_busy", 64'(bus.busy), 64'd0);
      check("spur_resp_valid", 64'(bus.resp_valid), 64'd0);
    end
    @(posedge clk); #1;
    spur = 1'b0;

`ifndef SIMD_ISSUE_TIMEOUT_EN
    // slow MAC: latency counter saturates
    lat_ovr = 20;
    do_req(2'b01, 32'h12345678, 32'h9ABCDEF0, 5'd11, 1);
    wait_quiet(60);
    lat_ovr = 0;
`endif

    // randomized traffic with random writeback stalls
    rr_mode = 1;
    for (int i = 0; i < 24; i++) begin
      do_req(2'($urandom_range(0, 3)), $urandom, $urandom, 5'($urandom_range(0, 31)), 1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    rr_mode = 0;
    wait_quiet(200);

    // MAC that never answers
    stub_en = 1'b0;
`ifdef SIMD_ISSUE_TIMEOUT_EN
    do_req(2'b01, 32'hCAFEF00D, 32'h0BADBEEF, 5'd12, 2);
    wait_quiet(60);
    stub_en = 1'b1;
`else
    do_req(2'b01, 32'hCAFEF00D, 32'h0BADBEEF, 5'd12, 0);
    repeat (100) begin
      @(negedge clk);
      check("hang_busy", 64'(bus.busy), 64'd1);
      check("hang_resp_valid", 64'(bus.resp_valid), 64'd0);
    end
    stub_en = 1'b1;
    pulse_reset();
`endif
    do_req(2'b11, 32'h02FF0000, 32'h03020000, 5'd13, 1);
    wait_quiet(40);

    check("queue_empty", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
